// File: rtl/watch_pkg.sv
// -----------------------------------------------------------------------------
// watch_pkg
// Shared definitions for the stopwatch run/lap sequencer:
//   - one-hot state encodings for the sequencer FSM
//   - debounce stability counter width
//   - lap counter width and its saturating increment helper
// -----------------------------------------------------------------------------
package watch_pkg;

  localparam int STATE_W  = 6;
  localparam int DB_CNT_W = 8;
  localparam int LAPNUM_W = 4;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_CLEAR       = 6'b000001;
  localparam state_t ST_ZERO        = 6'b000010;
  localparam state_t ST_RUN         = 6'b000100;
  localparam state_t ST_RUN_LAP     = 6'b001000;
  localparam state_t ST_STOPPED     = 6'b010000;
  localparam state_t ST_STOPPED_LAP = 6'b100000;

  localparam logic [LAPNUM_W-1:0] LAPNUM_MAX = 4'd15;

  // Lap counter increment that sticks at its maximum value.
  function automatic logic [LAPNUM_W-1:0] lapnum_inc(input logic [LAPNUM_W-1:0] v);
    logic [LAPNUM_W-1:0] r;
    if (v == LAPNUM_MAX) begin
      r = LAPNUM_MAX;
    end else begin
      r = v + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronises a raw button, filters it with a TICK-gated stability counter and
// emits a one-CLK pulse on each rising edge of the filtered level.
// Ports:
//   CLK    in  system clock
//   RESET  in  asynchronous active-high reset
//   TICK   in  one-CLK sampling strobe
//   btn    in  raw asynchronous button level
//   pulse  out registered one-CLK pulse per debounced press
// -----------------------------------------------------------------------------
module btn_debounce
  import watch_pkg::*;
#(
  parameter int DB_TICKS = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic TICK,
  input  logic btn,
  output logic pulse
);

  localparam logic [DB_CNT_W-1:0] DB_LIMIT = DB_CNT_W'(DB_TICKS - 1);

  logic [1:0]          sync_r;
  logic                level_r;
  logic                level_nxt_s;
  logic [DB_CNT_W-1:0] cnt_r;
  logic [DB_CNT_W-1:0] cnt_nxt_s;
  logic                armed_r;
  logic                pulse_r;

  // Two-flop synchroniser. Resets to "pressed" so a button held through reset
  // cannot be mistaken for a fresh press once the pipeline fills.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], btn};
    end
  end

  // Stability counter: counts TICKs that disagree with the filtered level,
  // any agreeing TICK restarts the count.
  always_comb begin
    level_nxt_s = level_r;
    cnt_nxt_s   = cnt_r;
    if (TICK) begin
      if (sync_r[1] != level_r) begin
        if (cnt_r == DB_LIMIT) begin
          level_nxt_s = ~level_r;
          cnt_nxt_s   = {DB_CNT_W{1'b0}};
        end else begin
          level_nxt_s = level_r;
          cnt_nxt_s   = cnt_r + DB_CNT_W'(1);
        end
      end else begin
        level_nxt_s = level_r;
        cnt_nxt_s   = {DB_CNT_W{1'b0}};
      end
    end else begin
      level_nxt_s = level_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Filter state, release-arming flag and edge pulse register. Pulses are only
  // allowed once the synchronised button has been seen released after reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      level_r <= 1'b0;
      cnt_r   <= {DB_CNT_W{1'b0}};
      armed_r <= 1'b0;
      pulse_r <= 1'b0;
    end else begin
      level_r <= level_nxt_s;
      cnt_r   <= cnt_nxt_s;
      armed_r <= armed_r | ~sync_r[1];
      pulse_r <= level_nxt_s & ~level_r & armed_r;
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/watch_lap_ctrl.sv
// -----------------------------------------------------------------------------
// watch_lap_ctrl
// Stopwatch run/lap sequencer between the front-panel buttons and the BCD
// time-count datapath.
// Ports:
//   CLK      in  system clock
//   RESET    in  asynchronous active-high reset
//   TICK     in  one-CLK time-base strobe
//   locked   in  clock-manager lock, counting only while high
//   STRTSTOP in  raw start/stop button
//   LAP      in  raw lap/reset button
//   CLKEN    out counter increment enable (TICK gated)
//   RST      out counter synchronous clear
//   LATCH    out one-cycle display capture pulse
//   LAPHOLD  out display shows captured value
//   LAPNUM   out lap capture count, saturating (only with WATCH_LAP_COUNT_EN)
// Build option: define WATCH_LAP_COUNT_EN to add the LAPNUM lap counter.
// -----------------------------------------------------------------------------
module watch_lap_ctrl
  import watch_pkg::*;
#(
  parameter int DB_TICKS = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic TICK,
  input  logic locked,
  input  logic STRTSTOP,
  input  logic LAP,
  output logic CLKEN,
  output logic RST,
  output logic LATCH,
  output logic LAPHOLD
`ifdef WATCH_LAP_COUNT_EN
  ,
  output logic [LAPNUM_W-1:0] LAPNUM
`endif
);

  logic   start_p_s;
  logic   lap_p_s;
  state_t state_r;
  state_t state_nxt_s;
  logic   rst_r;
  logic   latch_r;
  logic   laphold_r;
  logic   rst_nxt_s;
  logic   latch_nxt_s;
  logic   laphold_nxt_s;

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_start (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (TICK),
    .btn   (STRTSTOP),
    .pulse (start_p_s)
  );

  btn_debounce #(.DB_TICKS(DB_TICKS)) u_db_lap (
    .CLK   (CLK),
    .RESET (RESET),
    .TICK  (TICK),
    .btn   (LAP),
    .pulse (lap_p_s)
  );

  // Sequencer state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode. Start/stop is tested first so it wins over a
  // simultaneous lap press; any non one-hot code falls back to CLEAR.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        state_nxt_s = ST_ZERO;
      end
      ST_ZERO: begin
        if (start_p_s && locked) state_nxt_s = ST_RUN;
        else                     state_nxt_s = ST_ZERO;
      end
      ST_RUN: begin
        if (!locked || start_p_s) state_nxt_s = ST_STOPPED;
        else if (lap_p_s)         state_nxt_s = ST_RUN_LAP;
        else                      state_nxt_s = ST_RUN;
      end
      ST_RUN_LAP: begin
        if (!locked || start_p_s) state_nxt_s = ST_STOPPED_LAP;
        else if (lap_p_s)         state_nxt_s = ST_RUN;
        else                      state_nxt_s = ST_RUN_LAP;
      end
      ST_STOPPED: begin
        if (start_p_s && locked) state_nxt_s = ST_RUN;
        else if (lap_p_s)        state_nxt_s = ST_CLEAR;
        else                     state_nxt_s = ST_STOPPED;
      end
      ST_STOPPED_LAP: begin
        if (start_p_s && locked) state_nxt_s = ST_RUN_LAP;
        else if (lap_p_s)        state_nxt_s = ST_STOPPED;
        else                     state_nxt_s = ST_STOPPED_LAP;
      end
      default: begin
        state_nxt_s = ST_CLEAR;
      end
    endcase
  end

  // Output decode. Registered outputs are computed from the next state so
  // they line up with the state register; CLKEN is the only combinational one.
  always_comb begin
    rst_nxt_s     = (state_nxt_s == ST_CLEAR);
    laphold_nxt_s = (state_nxt_s == ST_RUN_LAP) || (state_nxt_s == ST_STOPPED_LAP);
    latch_nxt_s   = (state_r == ST_RUN) && (state_nxt_s == ST_RUN_LAP);
    CLKEN         = TICK & ((state_r == ST_RUN) || (state_r == ST_RUN_LAP));
  end

  // Output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rst_r     <= 1'b1;
      latch_r   <= 1'b0;
      laphold_r <= 1'b0;
    end else begin
      rst_r     <= rst_nxt_s;
      latch_r   <= latch_nxt_s;
      laphold_r <= laphold_nxt_s;
    end
  end

  assign RST     = rst_r;
  assign LATCH   = latch_r;
  assign LAPHOLD = laphold_r;

`ifdef WATCH_LAP_COUNT_EN
  logic [LAPNUM_W-1:0] lapnum_r;

  // Lap capture counter: advances with every LATCH, cleared while in CLEAR.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lapnum_r <= {LAPNUM_W{1'b0}};
    end else if (state_r == ST_CLEAR) begin
      lapnum_r <= {LAPNUM_W{1'b0}};
    end else if (latch_nxt_s) begin
      lapnum_r <= lapnum_inc(lapnum_r);
    end else begin
      lapnum_r <= lapnum_r;
    end
  end

  assign LAPNUM = lapnum_r;
`endif

endmodule

// File: doc/watch_lap_ctrl.md
Name: watch_lap_ctrl

Overview:
- Stopwatch run/lap sequencer that sits between the raw front-panel buttons and the time-count datapath.
- Debounces the START/STOP and LAP buttons and turns each press into a one-clock pulse.
- Drives count enable and count clear for the BCD counter, plus capture and freeze controls for the display register.
- Replaces the plain start/stop controller when split-time display is required.

Parameters:
- DB_TICKS, 4, number of consecutive TICK samples a synchronised button level must hold before the debounced level changes (range 1..255).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- TICK  in  1  one-CLK-wide time-base strobe (e.g. 100 Hz); gates counting and debounce sampling.
- locked  in  1  clock-manager lock; counting is only permitted while high.
- STRTSTOP  in  1  raw start/stop button, asynchronous, active-high.
- LAP  in  1  raw lap/reset button, asynchronous, active-high.
- CLKEN  out  1  counter increment enable.
- RST  out  1  counter synchronous clear.
- LATCH  out  1  one-cycle pulse; display register captures the live count.
- LAPHOLD  out  1  display shows the captured value instead of the live count.

Behaviour:
- Debounce, per button:
  - 2-FF synchroniser.
  - Level counter advanced only on TICK; the debounced level flips after DB_TICKS consecutive TICKs with the synchronised input differing from it.
  - Any mismatch-free TICK clears the counter.
  - Rising edge of the debounced level gives a 1-CLK pulse: start_p or lap_p.
  - Falling edges produce nothing.
- FSM, one-hot, states CLEAR, ZERO, RUN, RUN_LAP, STOPPED, STOPPED_LAP. On RESET the state is CLEAR and debounce levels and counters are 0.
  - CLEAR: go to ZERO unconditionally next cycle.
  - ZERO: start_p & locked -> RUN. lap_p ignored.
  - RUN: locked=0 or start_p -> STOPPED. Otherwise lap_p -> RUN_LAP.
  - RUN_LAP: locked=0 or start_p -> STOPPED_LAP. Otherwise lap_p -> RUN (releases the hold).
  - STOPPED: start_p & locked -> RUN. Otherwise lap_p -> CLEAR.
  - STOPPED_LAP: start_p & locked -> RUN_LAP. Otherwise lap_p -> STOPPED.
  - Simultaneous start_p and lap_p: the start/stop transition wins and lap_p is dropped.
- Outputs (Moore, decoded from the state register except CLKEN):
  - RST = 1 in CLEAR, including throughout RESET.
  - CLKEN = TICK & (RUN | RUN_LAP). Combinational AND with TICK; exactly one enable per TICK.
  - LAPHOLD = 1 in RUN_LAP and STOPPED_LAP.
  - LATCH is registered and high for exactly the first CLK cycle after RUN -> RUN_LAP. No LATCH on STOPPED_LAP <-> RUN_LAP, nor on release.
- Reset values: RST=1, CLKEN=0, LATCH=0, LAPHOLD=0.
- Latency: state change occurs on the CLK edge after the pulse. Press-to-pulse latency is 2 CLK sync + DB_TICKS TICKs + 1 CLK.
- Reset mid-operation returns to CLEAR immediately. A button held through reset release generates no pulse until it is released and pressed again.
- locked falling during ZERO/STOPPED has no effect.
- Illegal state encoding -> CLEAR next cycle.

Optional Feature:
- Macro: WATCH_LAP_COUNT_EN.
- When defined:
  - Adds output LAPNUM (out, 4 bits).
  - LAPNUM increments on every LATCH and saturates at 15.
  - LAPNUM is cleared in CLEAR and by RESET.
- When undefined: no port, no logic; behaviour is otherwise identical.

Decomposition:
- Shared package watch_pkg:
  - state encoding constants for the six one-hot states;
  - DB counter width rule (8 bits);
  - LAPNUM width (4).
- One sub-module, btn_debounce: synchroniser, TICK-gated stability counter and rising-edge pulse. Instantiated twice, parameterised by DB_TICKS.

Test Plan:
Bench setup: DB_TICKS=4, TICK every 10 CLK.
1. Reset/idle: assert RESET 3 CLK, then release. Required: RST=1 during reset and first cycle; then ZERO with RST=0, CLKEN=0, LAPHOLD=0.
2. Start counting: press STRTSTOP 60 CLK with locked=1.
   - Required: RUN within 2+4 TICKs+1.
   - CLKEN pulses coincide with TICK, 10 pulses per 100 CLK.
   - Bounce (5-CLK glitches) produces no extra pulse.
3. Lap: in RUN, press LAP. Required: LATCH high exactly 1 CLK, LAPHOLD=1, CLKEN continues. Second LAP press -> LAPHOLD=0, no LATCH.
4. Stop/clear:
   - From RUN_LAP press STRTSTOP -> STOPPED_LAP, CLKEN=0, LAPHOLD=1.
   - LAP -> STOPPED, LAPHOLD=0.
   - LAP again -> CLEAR: RST 1 cycle, then ZERO.
5. Lock loss / simultaneous press:
   - Drop locked in RUN -> STOPPED next CLK.
   - With locked=0, a STRTSTOP press stays STOPPED.
   - Pressing both buttons together in STOPPED with locked=1 -> RUN, not CLEAR.
6. With WATCH_LAP_COUNT_EN: 17 lap captures give LAPNUM 1..15 and then hold at 15. A CLEAR returns LAPNUM to 0.
